opl3_reg_write_queue: RTL and testbench



---
 rtl/opl3_reg_write_queue.sv | 178 +++++++++++++++++
 tb/tb_opl3_reg_write_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opl3_reg_write_queue.sv
// Register-write queue: buffers host {address, data} writes in a FIFO and drains them,
// paced, into a register-file write port. Define OPL3_REG_WRITE_QUEUE_STATS_EN for high_water/drop_count.
//
// state | meaning
// IDLE  | may pop the FIFO head into the memory write port
// GAP   | enforcing idle cycles after a drained write; drain_en ignored
module opl3_reg_write_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int WRITE_GAP  = 4
) (
  input  logic                    clk,
  input  logic                    ic_n,
  input  logic                    wr,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    overflow_clr,
  input  logic                    drain_en,
  output logic                    wea,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [DATA_WIDTH-1:0]   dia
`ifdef OPL3_REG_WRITE_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]  high_water,
  output logic [15:0]             drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int GW = (WRITE_GAP > 1) ? $clog2(WRITE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (WRITE_GAP > 0) ? GW'(WRITE_GAP - 1) : '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [LW-1:0]           wptr_q, wptr_d;
  logic [LW-1:0]           rptr_q, rptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic                    wea_q, wea_d;
  logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
  logic [DATA_WIDTH-1:0]   dia_q, dia_d;
  logic [EW-1:0]           mem_q [DEPTH];

  logic push;
  logic pop;
  logic drop;

  // Full/empty come straight from the registered pointers, so they agree with level_q every cycle.
  assign full  = (wptr_q[PW-1:0] == rptr_q[PW-1:0]) && (wptr_q[PW] != rptr_q[PW]);
  assign empty = (wptr_q == rptr_q);
  assign push  = wr && !full;
  assign drop  = wr && full;
  assign pop   = (state_q == S_IDLE) && !empty && drain_en;

  always_comb begin
    wptr_d  = wptr_q + LW'(push);
    rptr_d  = rptr_q + LW'(pop);
    level_d = wptr_d - rptr_d;
    ovf_d   = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PW-1:0]] <= {wr_addr, wr_data};
    end
  end

  // FSM state register plus the registered pointers and write-port outputs.
  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dia_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dia_q   <= dia_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (pop && (WRITE_GAP != 0)) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  always_comb begin
    wea_d   = pop;
    addra_d = addra_q;
    dia_d   = dia_q;
    if (pop) begin
      {addra_d, dia_d} = mem_q[rptr_q[PW-1:0]];
    end
  end

  assign level    = level_q;
  assign overflow = ovf_q;
  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dia      = dia_q;

`ifdef OPL3_REG_WRITE_QUEUE_STATS_EN
  logic [LW-1:0] hw_q, hw_d;
  logic [15:0]   dc_q, dc_d;

  always_comb begin
    hw_d = (level_d > hw_q) ? level_d : hw_q;
    dc_d = dc_q;
    // A drop coinciding with the clear is still counted, mirroring overflow.
    if (overflow_clr) begin
      dc_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (dc_q != 16'hFFFF)) begin
      dc_d = dc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      hw_q <= '0;
      dc_q <= '0;
    end else begin
      hw_q <= hw_d;
      dc_q <= dc_d;
    end
  end

  assign high_water = hw_q;
  assign drop_count = dc_q;
`endif

endmodule

// File: tb/tb_opl3_reg_write_queue.sv
// Bench for opl3_reg_write_queue: one WRITE_GAP=4 instance and one WRITE_GAP=0 instance share
// stimulus; a queue-based model is compared every cycle, plus hand-computed literal checks.
module tb_opl3_reg_write_queue;

  localparam int DEPTH = 16;

  logic       clk;
  logic       ic_n;
  logic       wr;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       overflow_clr;
  logic       drain_en;

  logic       full0, empty0, ovf0, wea0;
  logic [4:0] level0;
  logic [8:0] addra0;
  logic [7:0] dia0;
  logic       full1, empty1, ovf1, wea1;
  logic [4:0] level1;
  logic [8:0] addra1;
  logic [7:0] dia1;
`ifdef OPL3_REG_WRITE_QUEUE_STATS_EN
  logic [4:0]  hw0, hw1;
  logic [15:0] dc0, dc1;
`endif

  opl3_reg_write_queue #(.DEPTH(16), .ADDR_WIDTH(9), .DATA_WIDTH(8), .WRITE_GAP(4)) u_dut (
    .clk(clk), .ic_n(ic_n), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full0), .empty(empty0), .level(level0), .overflow(ovf0),
    .overflow_clr(overflow_clr), .drain_en(drain_en),
    .wea(wea0), .addra(addra0), .dia(dia0)
`ifdef OPL3_REG_WRITE_QUEUE_STATS_EN
    , .high_water(hw0), .drop_count(dc0)
`endif
  );

  opl3_reg_write_queue #(.DEPTH(16), .ADDR_WIDTH(9), .DATA_WIDTH(8), .WRITE_GAP(0)) u_dut_g0 (
    .clk(clk), .ic_n(ic_n), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .full(full1), .empty(empty1), .level(level1), .overflow(ovf1),
    .overflow_clr(overflow_clr), .drain_en(drain_en),
    .wea(wea1), .addra(addra1), .dia(dia1)
`ifdef OPL3_REG_WRITE_QUEUE_STATS_EN
    , .high_water(hw1), .drop_count(dc1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit run = 0;

  // Model state: one queue per instance, a count of remaining idle cycles, and the expected outputs.
  logic [16:0] mq0 [$];
  logic [16:0] mq1 [$];
  int   m_gap  [2] = '{0, 0};
  int   m_wea  [2] = '{0, 0};
  int   m_addr [2] = '{0, 0};
  int   m_data [2] = '{0, 0};
  int   m_ovf  [2] = '{0, 0};
  int   m_hw   [2] = '{0, 0};
  int   m_dc   [2] = '{0, 0};

  // Drain log: cycle number, address and data of every wea pulse.
  int t0 [$];
  int a0 [$];
  int t1 [$];
  int a1 [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s [dut%0d]: got 0x%0h, expected 0x%0h at cycle %0d", nm, d, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model, updated on the same edges as the DUT.
  initial begin
    int n;
    bit pop, push, drop, fl;
    logic [16:0] e;
    forever begin
      @(posedge clk or negedge ic_n);
      if (!ic_n) begin
        mq0.delete();
        mq1.delete();
        for (int d = 0; d < 2; d++) begin
          m_gap[d] = 0; m_wea[d] = 0; m_addr[d] = 0; m_data[d] = 0;
          m_ovf[d] = 0; m_hw[d] = 0;  m_dc[d] = 0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          n    = (d == 0) ? mq0.size() : mq1.size();
          fl   = (n == DEPTH);
          pop  = (m_gap[d] == 0) && (n != 0) && drain_en;
          push = wr && !fl;
          drop = wr && fl;
          if (pop) begin
            if (d == 0) e = mq0.pop_front();
            else        e = mq1.pop_front();
            m_wea[d]  = 1;
            m_addr[d] = int'(e[16:8]);
            m_data[d] = int'(e[7:0]);
            m_gap[d]  = gap_of(d);
          end else begin
            m_wea[d] = 0;
            if (m_gap[d] > 0) m_gap[d]--;
          end
          if (push) begin
            if (d == 0) mq0.push_back({wr_addr, wr_data});
            else        mq1.push_back({wr_addr, wr_data});
          end
          if (drop) m_ovf[d] = 1;
          else if (overflow_clr) m_ovf[d] = 0;
          if (overflow_clr) m_dc[d] = drop ? 1 : 0;
          else if (drop && m_dc[d] < 65535) m_dc[d]++;
          n = (d == 0) ? mq0.size() : mq1.size();
          if (n > m_hw[d]) m_hw[d] = n;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus the drain log.
  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (run) begin
        if (wea0) begin t0.push_back(cyc); a0.push_back({addra0, dia0}); end
        if (wea1) begin t1.push_back(cyc); a1.push_back({addra1, dia1}); end
        for (int d = 0; d < 2; d++) begin
          n = (d == 0) ? mq0.size() : mq1.size();
          chk("m_wea",   d, (d == 0) ? wea0   : wea1,   m_wea[d]);
          chk("m_addra", d, (d == 0) ? addra0 : addra1, m_addr[d]);
          chk("m_dia",   d, (d == 0) ? dia0   : dia1,   m_data[d]);
          chk("m_level", d, (d == 0) ? level0 : level1, n);
          chk("m_full",  d, (d == 0) ? full0  : full1,  n == DEPTH);
          chk("m_empty", d, (d == 0) ? empty0 : empty1, n == 0);
          chk("m_ovf",   d, (d == 0) ? ovf0   : ovf1,   m_ovf[d]);
`ifdef OPL3_REG_WRITE_QUEUE_STATS_EN
          chk("m_hw",    d, (d == 0) ? hw0    : hw1,    m_hw[d]);
          chk("m_dc",    d, (d == 0) ? dc0    : dc1,    m_dc[d]);
`endif
        end
      end
    end
  end

  task automatic clear_logs();
    t0.delete(); a0.delete(); t1.delete(); a1.delete();
  endtask

  initial begin
    ic_n = 1'b0; wr = 1'b0; wr_addr = '0; wr_data = '0;
    overflow_clr = 1'b0; drain_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 ic_n = 1'b1;
    run = 1'b1;

    // Reset state
    chk("rst_empty", 0, empty0, 1);
    chk("rst_level", 0, level0, 0);
    chk("rst_full",  0, full0, 0);
    chk("rst_wea",   0, wea0, 0);
    chk("rst_addra", 0, addra0, 0);
    chk("rst_ovf",   1, ovf1, 0);

    // Single write: wea two edges after the push
    tick();
    wr = 1'b1; wr_addr = 9'h105; wr_data = 8'hA5; drain_en = 1'b1;
    tick();
    wr = 1'b0;
    chk("t1_empty_after_push", 0, empty0, 0);
    chk("t1_no_wea_yet",       0, wea0, 0);
    tick();
    chk("t1_wea",   0, wea0, 1);
    chk("t1_addra", 0, addra0, 'h105);
    chk("t1_dia",   0, dia0, 'hA5);
    chk("t1_empty", 0, empty0, 1);
    tick();
    chk("t1_wea_drop", 0, wea0, 0);
    chk("t1_hold_addra", 0, addra0, 'h105);
    drain_en = 1'b0;
    repeat (6) tick();

    // Fill, overflow, then paced drain in order
    clear_logs();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; wr_addr = 9'h040 + 9'(i); wr_data = 8'hC0 ^ 8'(i);
      tick();
    end
    wr = 1'b0;
    chk("t2_level16", 0, level0, 16);
    chk("t2_full",    0, full0, 1);
    chk("t2_no_ovf",  0, ovf0, 0);
    wr = 1'b1; wr_addr = 9'h1FF; wr_data = 8'hEE;
    tick();
    wr = 1'b0;
    chk("t2_ovf",       0, ovf0, 1);
    chk("t2_level_kept", 0, level0, 16);
    drain_en = 1'b1;
    for (int k = 0; k < 120 && t0.size() < 16; k++) tick();
    chk("t2_pulses", 0, t0.size(), 16);
    for (int i = 0; i < 16 && i < t0.size(); i++) begin
      chk("t2_order", 0, a0[i], {9'h040 + 9'(i), 8'hC0 ^ 8'(i)});
      if (i > 0) chk("t2_spacing", 0, t0[i] - t0[i-1], 5);
    end
    chk("t2_g0_pulses", 1, t1.size(), 16);
    for (int i = 1; i < 16 && i < t1.size(); i++)
      chk("t2_g0_consecutive", 1, t1[i] - t1[i-1], 1);
    chk("t2_empty", 0, empty0, 1);
    drain_en = 1'b0;
    repeat (2) tick();

    // 8 entries, WRITE_GAP=0 instance drains back-to-back
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wr_addr = 9'h0A0 + 9'(i); wr_data = 8'h10 + 8'(i);
      tick();
    end
    wr = 1'b0;
    drain_en = 1'b1;
    for (int k = 0; k < 30 && t1.size() < 8; k++) tick();
    chk("t3_g0_pulses", 1, t1.size(), 8);
    for (int i = 0; i < 8 && i < t1.size(); i++) begin
      chk("t3_g0_order", 1, a1[i], {9'h0A0 + 9'(i), 8'h10 + 8'(i)});
      if (i > 0) chk("t3_g0_consecutive", 1, t1[i] - t1[i-1], 1);
    end
    tick();
    chk("t3_g0_empty", 1, empty1, 1);
    for (int k = 0; k < 60 && t0.size() < 8; k++) tick();
    chk("t3_pulses", 0, t0.size(), 8);
    tick();
    chk("t3_empty", 0, empty0, 1);
    drain_en = 1'b0;
    repeat (5) tick();

    // Simultaneous push/pop at level 3; drop at full despite a pop
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t4_ovf_cleared", 0, ovf0, 0);
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wr_addr = 9'h0C0 + 9'(i); wr_data = 8'h30 + 8'(i);
      tick();
    end
    chk("t4_level3", 0, level0, 3);
    wr_addr = 9'h0C3; wr_data = 8'h33; drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    chk("t4_pushpop_level", 0, level0, 3);
    chk("t4_pushpop_wea",   0, wea0, 1);
    chk("t4_pushpop_addra", 0, addra0, 'h0C0);
    for (int i = 0; i < 13; i++) begin
      wr_addr = 9'h0D0 + 9'(i); wr_data = 8'h50 + 8'(i);
      tick();
    end
    chk("t4_full",    0, full0, 1);
    chk("t4_level16", 0, level0, 16);
    wr_addr = 9'h1AA; wr_data = 8'h77; drain_en = 1'b1;
    tick();
    wr = 1'b0; drain_en = 1'b0;
    chk("t4_drop_level", 0, level0, 15);
    chk("t4_drop_ovf",   0, ovf0, 1);
    chk("t4_drop_wea",   0, wea0, 1);
    chk("t4_drop_addra", 0, addra0, 'h0C1);

    // Reset during GAP with 5 entries queued
    ic_n = 1'b0;
    tick();
    ic_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; wr_addr = 9'h0E0 + 9'(i); wr_data = 8'h60 + 8'(i);
      tick();
    end
    wr = 1'b0;
    chk("t5_level6", 0, level0, 6);
    drain_en = 1'b1;
    tick();
    drain_en = 1'b0;
    chk("t5_pop_wea",  0, wea0, 1);
    chk("t5_level5",   0, level0, 5);
    tick();
    chk("t5_gap_wea",  0, wea0, 0);
    #2 ic_n = 1'b0;
    #1;
    chk("t5_rst_wea",   0, wea0, 0);
    chk("t5_rst_empty", 0, empty0, 1);
    chk("t5_rst_level", 0, level0, 0);
    chk("t5_rst_ovf",   0, ovf0, 0);
    chk("t5_rst_level", 1, level1, 0);
    tick();
    tick();
    ic_n = 1'b1;
    clear_logs();
    drain_en = 1'b1;
    repeat (10) tick();
    chk("t5_no_write", 0, t0.size(), 0);
    chk("t5_no_write", 1, t1.size(), 0);
    chk("t5_still_empty", 0, empty0, 1);
    drain_en = 1'b0;

`ifdef OPL3_REG_WRITE_QUEUE_STATS_EN
    // 20 writes into an undrained FIFO
    ic_n = 1'b0;
    tick();
    ic_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; wr_addr = 9'h100 + 9'(i); wr_data = 8'(i);
      tick();
    end
    wr = 1'b0;
    chk("t6_high_water", 0, hw0, 16);
    chk("t6_drop_count", 0, dc0, 4);
    chk("t6_ovf",        0, ovf0, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t6_dc_cleared",  0, dc0, 0);
    chk("t6_ovf_cleared", 0, ovf0, 0);
    chk("t6_hw_kept",     0, hw0, 16);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
